// File: rtl/control_unit_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface control_unit_if;
  logic        Run;
  logic [15:0] DIN;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout;
  logic        Ain;
  logic        Gin;
  logic        Gout;
  logic        soma;
  logic        add_sub;
  logic        zero;
  logic        comparacao;
  logic        maior_menor;
  logic        Done;

  modport master (
    input  Run, DIN,
    output IRin, Rin, Rout, DINout, Ain, Gin, Gout,
           soma, add_sub, zero, comparacao, maior_menor, Done
  );

  modport slave (
    output Run, DIN,
    input  IRin, Rin, Rout, DINout, Ain, Gin, Gout,
           soma, add_sub, zero, comparacao, maior_menor, Done
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle T0..T3 sequencer: fetches an instruction word into IR and drives
// register enables, bus selects and one-hot ALU operation selects.
module control_unit (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  state_t state_reg, state_next;
  // IR[5:0] carries no meaning, so only the opcode and the two register fields are kept
  logic [15:6] ir_reg;

  logic [3:0] opcode;
  logic [2:0] x_sel, y_sel;
  logic [7:0] x_onehot, y_onehot;

  assign opcode   = ir_reg[15:12];
  assign x_sel    = ir_reg[11:9];
  assign y_sel    = ir_reg[8:6];
  assign x_onehot = 8'd1 << x_sel;
  assign y_onehot = 8'd1 << y_sel;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= T0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == T0 && bus.Run)
        ir_reg <= bus.DIN[15:6];
    end
  end

  logic       irin_c, dinout_c, ain_c, gin_c, gout_c, done_c;
  logic       soma_c, add_sub_c, zero_c, comparacao_c, maior_menor_c;
  logic [7:0] rin_c, rout_c;

  always_comb begin
    state_next    = state_reg;
    irin_c        = 1'b0;
    rin_c         = 8'h00;
    rout_c        = 8'h00;
    dinout_c      = 1'b0;
    ain_c         = 1'b0;
    gin_c         = 1'b0;
    gout_c        = 1'b0;
    soma_c        = 1'b0;
    add_sub_c     = 1'b0;
    zero_c        = 1'b0;
    comparacao_c  = 1'b0;
    maior_menor_c = 1'b0;
    done_c        = 1'b0;

    case (state_reg)
      T0: begin
        // Reset forces T0 asynchronously; masking here keeps IRin low during reset too
        irin_c = bus.Run & ~Reset;
        if (bus.Run)
          state_next = T1;
      end
      T1: begin
        case (opcode)
          4'd0: begin
            rout_c     = y_onehot;
            rin_c      = x_onehot;
            done_c     = 1'b1;
            state_next = T0;
          end
          4'd1: begin
            dinout_c   = 1'b1;
            rin_c      = x_onehot;
            done_c     = 1'b1;
            state_next = T0;
          end
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            rout_c     = x_onehot;
            ain_c      = 1'b1;
            state_next = T2;
          end
          default: begin
            done_c     = 1'b1;
            state_next = T0;
          end
        endcase
      end
      T2: begin
        rout_c     = y_onehot;
        gin_c      = 1'b1;
        state_next = T3;
        case (opcode)
          4'd2:    soma_c = 1'b1;
          4'd3: begin
            soma_c    = 1'b1;
            add_sub_c = 1'b1;
          end
          4'd4:    zero_c        = 1'b1;
          4'd5:    comparacao_c  = 1'b1;
          4'd6:    maior_menor_c = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        gout_c     = 1'b1;
        rin_c      = x_onehot;
        done_c     = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
  end

  assign bus.IRin        = irin_c;
  assign bus.Rin         = rin_c;
  assign bus.Rout        = rout_c;
  assign bus.DINout      = dinout_c;
  assign bus.Ain         = ain_c;
  assign bus.Gin         = gin_c;
  assign bus.Gout        = gout_c;
  assign bus.soma        = soma_c;
  assign bus.add_sub     = add_sub_c;
  assign bus.zero        = zero_c;
  assign bus.comparacao  = comparacao_c;
  assign bus.maior_menor = maior_menor_c;
  assign bus.Done        = done_c;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 16-bit datapath. It captures each instruction word from `DIN` into an internal IR and sequences the datapath through fetch, decode, operand and write-back steps. It drives the register-file enables, the bus-mux selects and the one-hot operation selects (`soma`, `add_sub`, `zero`, `comparacao`, `maior_menor`) consumed by the add/sub/compare unit. It is the producer side of that unit's control interface.

## Interface
- No parameters. Register count is fixed at 8 and data width at 16.
- `Clock` in 1: single clock; everything updates on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears state and IR.
- `Run` in 1: start request, sampled only in state T0.
- `DIN` in 16: instruction or immediate word from the external data source.
- `IRin` out 1: IR load strobe; also exported to the datapath.
- `Rin` out 8: one-hot register write enable; bit n targets Rn.
- `Rout` out 8: one-hot register-to-bus select.
- `DINout` out 1: drive `DIN` onto the bus.
- `Ain` out 1: load A register from the bus.
- `Gin` out 1: load G register from the operation-unit output.
- `Gout` out 1: drive G onto the bus.
- `soma`, `add_sub`, `zero`, `comparacao`, `maior_menor` out 1 each: operation selects.
- `Done` out 1: one-cycle pulse when an instruction completes.

## Operation
- IR format:
  - `IR[15:12]` is the opcode.
  - `IR[11:9]` is X, the destination and first operand.
  - `IR[8:6]` is Y, the second operand.
  - `IR[5:0]` is ignored.
- Opcodes:
  - 0 mv: Rx ← Ry.
  - 1 mvi: Rx ← next `DIN`.
  - 2 add.
  - 3 sub.
  - 4 mvnz: Rx ← Ry if G≠0.
  - 5 seq.
  - 6 slt.
  - 7–15 are NOP.
- States T0, T1, T2, T3, encoded in 2 bits.
- All outputs are combinational from state and IR. Any output not listed for a state is 0.
- T0:
  - `IRin = Run`.
  - On the clock edge, if `Run`=1 then IR ← `DIN` and go to T1; otherwise stay in T0.
- T1, per opcode:
  - mv: `Rout[Y]`, `Rin[X]`, `Done`; then → T0.
  - mvi: `DINout`, `Rin[X]`, `Done`; then → T0. `DIN` must present the immediate in this cycle.
  - Ops 2–6: `Rout[X]`, `Ain`; then → T2.
  - NOP: `Done` only; then → T0.
- T2 (ops 2–6):
  - `Rout[Y]` and `Gin` asserted.
  - Exactly one operation select is asserted: add → `soma`; sub → `soma` + `add_sub`; mvnz → `zero`; seq → `comparacao`; slt → `maior_menor`.
  - Then → T3.
- T3: `Gout`, `Rin[X]`, `Done`; then → T0.
- Operation selects are never asserted outside T2. At most one of `soma`/`zero`/`comparacao`/`maior_menor` is high in any cycle.
- `add_sub` is high only together with `soma`.
- X = Y is legal; the same encoding and sequence apply.
- mvnz reads G as left by the previous ALU instruction. The datapath owns G; this block does not track it.
- `Run` is ignored in T1–T3. A `Run` held high in T0 starts a new fetch in the cycle right after `Done`.

## Timing
- Reset:
  - While `Reset`=1, every output is 0, including `IRin` regardless of `Run`.
  - State is T0 and IR is 0x0000.
  - This takes effect immediately, with no clock needed.
- Reset mid-instruction (T1–T3) aborts the instruction with no further `Rin` or `Done`. The first fetch after release happens in T0 with `Run`=1.
- Latency from the `Run`-sampling edge to `Done`:
  - mv, mvi, NOP: `Done` is high in the next cycle (T1); 2 cycles total including fetch.
  - ALU ops: `Done` is high in T3; 4 cycles total.
- `Done` is exactly one cycle wide. A back-to-back instruction gives T0 immediately after `Done`, so there is no bubble beyond T0.
- IR changes only on an edge where state = T0 and `Run` = 1.

## Test plan
- Reset: assert `Reset` during T2 of an add → all outputs 0 within the same cycle. After release with `Run`=0 for 5 cycles, state stays T0, `IRin`=0 and `Done` never pulses.
- mvi R0: `Run`=1 with `DIN`=0x1000, then `DIN`=0x00AB. Required in the next cycle: `DINout`=1, `Rin`=0x01, `Done`=1. The following cycle is T0.
- add R1,R2 (`DIN`=0x2280):
  - T1: `Rout`=0x02, `Ain`=1.
  - T2: `Rout`=0x04, `Gin`=1, `soma`=1, `add_sub`=0.
  - T3: `Gout`=1, `Rin`=0x02, `Done`=1.
- sub R7,R7 (0x3FC0): T1 `Rout`=0x80. T2 `Rout`=0x80, `soma`=1, `add_sub`=1. T3 `Rin`=0x80.
- Operation selects: for 0x4280, 0x5280 and 0x6280, T2 asserts only `zero`, only `comparacao` and only `maior_menor` respectively. `add_sub`=0 in all three.
- NOP: 0xF000 → T1 shows only `Done`=1, with `Rin`=`Rout`=0. `Run` held high → next fetch at the following edge. A `Run` pulse during T2 of an add has no effect.
